// File: rtl/ofs_plat_axi_lite_csr_pkg.sv
// Shared types and response codes for the AXI-lite to CSR bridge.
package ofs_plat_axi_lite_csr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ISSUE,
        ST_WR_RESP,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_RESP
    } t_csr_bridge_state;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ofs_plat_axi_lite_csr_bridge.sv
// AXI-lite slave terminating into a single-cycle CSR strobe interface.
// One transaction in flight; reads and writes share a round-robin grant.
//
// state       | meaning
// ------------+----------------------------------------------------
// ST_IDLE     | waiting for AW+W or AR; ready driven from grant
// ST_WR_ISSUE | csr_wr_en high, csr_wr_err sampled
// ST_WR_RESP  | bvalid held until bready
// ST_RD_ISSUE | csr_rd_en high
// ST_RD_WAIT  | counting RD_LATENCY, capture data on last count
// ST_RD_RESP  | rvalid held until rready
module ofs_plat_axi_lite_csr_bridge
    import ofs_plat_axi_lite_csr_pkg::*;
#(
    parameter  int ADDR_WIDTH = 20,
    parameter  int DATA_WIDTH = 64,
    parameter  int RD_LATENCY = 1,
    localparam int ADDR_LSB   = $clog2(DATA_WIDTH / 8),
    localparam int STRB_W     = DATA_WIDTH / 8,
    localparam int WORD_W     = ADDR_WIDTH - ADDR_LSB
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_W-1:0]     wstrb,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bresp,

    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,

    output logic                  csr_wr_en,
    output logic [WORD_W-1:0]     csr_wr_addr,
    output logic [DATA_WIDTH-1:0] csr_wr_data,
    output logic [STRB_W-1:0]     csr_wr_strb,
    input  logic                  csr_wr_err,
    output logic                  csr_rd_en,
    output logic [WORD_W-1:0]     csr_rd_addr,
    input  logic [DATA_WIDTH-1:0] csr_rd_data,
    input  logic                  csr_rd_err
);

    localparam int              CNT_W    = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

    t_csr_bridge_state    state_q;
    logic                 last_wr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 bvalid_q, rvalid_q, wr_en_q, rd_en_q;
    logic [1:0]           bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q, wr_data_q;
    logic [WORD_W-1:0]    wr_addr_q, rd_addr_q;
    logic [STRB_W-1:0]    wr_strb_q;

    logic idle, wr_elig, rd_elig, grant_wr, grant_rd;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^{awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};

    // On a tie the type not granted last time wins; a write wins the first tie.
    assign idle     = (state_q == ST_IDLE);
    assign wr_elig  = awvalid && wvalid;
    assign rd_elig  = arvalid;
    assign grant_wr = wr_elig && (!rd_elig || !last_wr_q);
    assign grant_rd = rd_elig && !grant_wr;

    assign awready = idle && grant_wr;
    assign wready  = idle && grant_wr;
    assign arready = idle && grant_rd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            last_wr_q <= 1'b0;
            cnt_q     <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            bresp_q   <= AXI_RESP_OKAY;
            rresp_q   <= AXI_RESP_OKAY;
            rdata_q   <= '0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_strb_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (awready) begin
                        state_q   <= ST_WR_ISSUE;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= awaddr[ADDR_WIDTH-1:ADDR_LSB];
                        wr_data_q <= wdata;
                        wr_strb_q <= wstrb;
                        last_wr_q <= 1'b1;
                    end else if (arready) begin
                        state_q   <= ST_RD_ISSUE;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= araddr[ADDR_WIDTH-1:ADDR_LSB];
                        last_wr_q <= 1'b0;
                    end
                end
                ST_WR_ISSUE: begin
                    bresp_q  <= csr_wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    bvalid_q <= 1'b1;
                    state_q  <= ST_WR_RESP;
                end
                ST_WR_RESP: begin
                    if (bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_RD_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        rdata_q  <= csr_rd_data;
                        rresp_q  <= csr_rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        rvalid_q <= 1'b1;
                        state_q  <= ST_RD_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RD_RESP: begin
                    if (rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bvalid      = bvalid_q;
    assign bresp       = bresp_q;
    assign rvalid      = rvalid_q;
    assign rdata       = rdata_q;
    assign rresp       = rresp_q;
    assign csr_wr_en   = wr_en_q;
    assign csr_wr_addr = wr_addr_q;
    assign csr_wr_data = wr_data_q;
    assign csr_wr_strb = wr_strb_q;
    assign csr_rd_en   = rd_en_q;
    assign csr_rd_addr = rd_addr_q;

endmodule

// File: tb/tb_ofs_plat_axi_lite_csr_bridge.sv
// Directed bench for the AXI-lite CSR bridge with a 3-cycle CSR read stub.
module tb_ofs_plat_axi_lite_csr_bridge;

    localparam int AW = 20;
    localparam int DW = 64;
    localparam int LAT = 3;
    localparam int WW = AW - 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic [AW-1:0] awaddr, araddr;
    logic [DW-1:0] wdata, rdata, csr_wr_data, csr_rd_data;
    logic [7:0]    wstrb, csr_wr_strb;
    logic [1:0]    bresp, rresp;
    logic          arvalid, arready, rvalid, rready;
    logic          csr_wr_en, csr_wr_err, csr_rd_en, csr_rd_err;
    logic [WW-1:0] csr_wr_addr, csr_rd_addr;

    logic [DW-1:0]  stub_data;
    logic           stub_err;
    logic [LAT-1:0] rd_pipe;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [7:0]    strb;
        logic          err;
        logic [WW-1:0] exp_addr;
        logic [1:0]    exp_resp;
    } vec_t;

    vec_t vecs [6];

    ofs_plat_axi_lite_csr_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
        .csr_wr_strb(csr_wr_strb), .csr_wr_err(csr_wr_err),
        .csr_rd_en(csr_rd_en), .csr_rd_addr(csr_rd_addr),
        .csr_rd_data(csr_rd_data), .csr_rd_err(csr_rd_err)
    );

    always #5 clk = ~clk;

    // CSR stub: valid data only in the cycle LAT after csr_rd_en, garbage otherwise.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_pipe <= '0;
        else          rd_pipe <= {rd_pipe[LAT-2:0], csr_rd_en};
    end
    assign csr_rd_data = rd_pipe[LAT-1] ? stub_data : 64'hBAD0_BAD0_BAD0_BAD0;
    assign csr_rd_err  = rd_pipe[LAT-1] ? stub_err  : ~stub_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " awready"}, awready, 0);
        chk({tag, " wready"}, wready, 0);
        chk({tag, " arready"}, arready, 0);
        chk({tag, " bvalid"}, bvalid, 0);
        chk({tag, " bresp"}, bresp, 0);
        chk({tag, " rvalid"}, rvalid, 0);
        chk({tag, " rdata"}, rdata, 0);
        chk({tag, " rresp"}, rresp, 0);
        chk({tag, " csr_wr_en"}, csr_wr_en, 0);
        chk({tag, " csr_wr_addr"}, csr_wr_addr, 0);
        chk({tag, " csr_wr_data"}, csr_wr_data, 0);
        chk({tag, " csr_wr_strb"}, csr_wr_strb, 0);
        chk({tag, " csr_rd_en"}, csr_rd_en, 0);
        chk({tag, " csr_rd_addr"}, csr_rd_addr, 0);
    endtask

    task automatic idle_inputs();
        awvalid = 0; wvalid = 0; arvalid = 0;
        bready = 0; rready = 0; csr_wr_err = 0;
    endtask

    task automatic do_write(input vec_t v, input string tag);
        @(posedge clk); #1;
        awvalid = 1; wvalid = 1; awaddr = v.addr; wdata = v.data; wstrb = v.strb;
        bready = 1; csr_wr_err = !v.err;
        @(negedge clk);
        chk({tag, " awready T"}, awready, 1);
        chk({tag, " wready T"}, wready, 1);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; wdata = ~v.data; wstrb = ~v.strb; csr_wr_err = v.err;
        @(negedge clk);
        chk({tag, " wr_en T+1"}, csr_wr_en, 1);
        chk({tag, " wr_addr"}, csr_wr_addr, v.exp_addr);
        chk({tag, " wr_data"}, csr_wr_data, v.data);
        chk({tag, " wr_strb"}, csr_wr_strb, v.strb);
        chk({tag, " bvalid T+1"}, bvalid, 0);
        @(posedge clk); #1;
        csr_wr_err = !v.err;
        @(negedge clk);
        chk({tag, " wr_en T+2"}, csr_wr_en, 0);
        chk({tag, " bvalid T+2"}, bvalid, 1);
        chk({tag, " bresp"}, bresp, v.exp_resp);
        chk({tag, " wr_data held"}, csr_wr_data, v.data);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, " bvalid T+3"}, bvalid, 0);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic do_read(input vec_t v, input string tag);
        @(posedge clk); #1;
        arvalid = 1; araddr = v.addr; rready = 1; stub_data = v.data; stub_err = v.err;
        @(negedge clk);
        chk({tag, " arready T"}, arready, 1);
        chk({tag, " awready T"}, awready, 0);
        @(posedge clk); #1;
        arvalid = 0; araddr = '0;
        @(negedge clk);
        chk({tag, " rd_en T+1"}, csr_rd_en, 1);
        chk({tag, " rd_addr"}, csr_rd_addr, v.exp_addr);
        chk({tag, " rvalid T+1"}, rvalid, 0);
        for (int i = 0; i < LAT; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk({tag, " rd_en wait"}, csr_rd_en, 0);
            chk({tag, " rvalid wait"}, rvalid, 0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, " rvalid T+5"}, rvalid, 1);
        chk({tag, " rdata"}, rdata, v.data);
        chk({tag, " rresp"}, rresp, v.exp_resp);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, " rvalid T+6"}, rvalid, 0);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        idle_inputs();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants, wr_cnt, rd_cnt, both_seen, seen;
        logic [7:0] order;
        vec_t v;

        vecs[0] = '{1'b1, 20'h00010, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b0, 17'h00002, 2'b00};
        vecs[1] = '{1'b0, 20'h00018, 64'h0000_0000_0000_1234, 8'h00, 1'b1, 17'h00003, 2'b10};
        vecs[2] = '{1'b1, 20'h00017, 64'h0123_4567_89AB_CDEF, 8'h0F, 1'b1, 17'h00002, 2'b10};
        vecs[3] = '{1'b0, 20'hFFFF8, 64'hA5A5_5A5A_F0F0_0F0F, 8'h00, 1'b0, 17'h1FFFF, 2'b00};
        vecs[4] = '{1'b1, 20'hFFFFF, 64'h8000_0000_0000_0001, 8'h81, 1'b0, 17'h1FFFF, 2'b00};
        vecs[5] = '{1'b0, 20'h00007, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b0, 17'h00000, 2'b00};

        reset_n = 0;
        idle_inputs();
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        stub_data = '0; stub_err = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        @(negedge clk);
        check_zero("reset");

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i], $sformatf("vec%0d wr", i));
            else               do_read(vecs[i], $sformatf("vec%0d rd", i));
        end

        // AW alone must not be accepted until W joins it.
        @(posedge clk); #1;
        awvalid = 1; wvalid = 0; awaddr = 20'h00100; wdata = 64'h1111; wstrb = 8'h03; bready = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("lone aw awready", awready, 0);
            chk("lone aw wready", wready, 0);
            chk("lone aw wr_en", csr_wr_en, 0);
            @(posedge clk); #1;
        end
        wvalid = 1;
        @(negedge clk);
        chk("aw+w awready", awready, 1);
        chk("aw+w wready", wready, 1);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        chk("aw+w wr_en", csr_wr_en, 1);
        chk("aw+w wr_addr", csr_wr_addr, 17'h00020);
        repeat (3) @(posedge clk);
        #1 idle_inputs();

        // Both request types permanently valid from reset: grants alternate.
        do_reset();
        awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
        awaddr = 20'h00020; araddr = 20'h00028; wdata = 64'h55; wstrb = 8'hFF;
        stub_data = 64'h77; stub_err = 0;
        grants = 0; wr_cnt = 0; rd_cnt = 0; both_seen = 0; order = '0;
        for (int c = 0; c < 100 && grants < 8; c++) begin
            @(negedge clk);
            if (csr_wr_en) wr_cnt++;
            if (csr_rd_en) rd_cnt++;
            if (awready && arready) both_seen++;
            if (awready) begin order[grants] = 1'b1; grants++; end
            else if (arready) begin order[grants] = 1'b0; grants++; end
        end
        @(posedge clk); #1;
        idle_inputs(); bready = 1; rready = 1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (csr_wr_en) wr_cnt++;
            if (csr_rd_en) rd_cnt++;
        end
        chk("alt grant count", grants, 8);
        chk("alt order", order, 8'b0101_0101);
        chk("alt wr_en count", wr_cnt, 4);
        chk("alt rd_en count", rd_cnt, 4);
        chk("alt simultaneous ready", both_seen, 0);
        @(posedge clk); #1 idle_inputs();

        // Write response stalled by bready=0 for 10 cycles.
        @(posedge clk); #1;
        awvalid = 1; wvalid = 1; awaddr = 20'h00040; wdata = 64'h99; wstrb = 8'h01;
        @(negedge clk);
        chk("stall awready", awready, 1);
        @(posedge clk); #1;
        arvalid = 1; araddr = 20'h00048; csr_wr_err = 1;
        stub_data = 64'h4242; stub_err = 0;
        @(negedge clk);
        chk("stall wr_en", csr_wr_en, 1);
        @(posedge clk); #1;
        csr_wr_err = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall bvalid", bvalid, 1);
            chk("stall bresp", bresp, 2'b10);
            chk("stall awready", awready, 0);
            chk("stall arready", arready, 0);
            @(posedge clk); #1;
        end
        bready = 1;
        @(negedge clk);
        chk("stall bvalid hs", bvalid, 1);
        chk("stall arready hs", arready, 0);
        @(posedge clk); #1;
        bready = 0;
        @(negedge clk);
        chk("stall bvalid after", bvalid, 0);
        chk("stall idle arready", arready, 1);
        chk("stall idle awready", awready, 0);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0; rready = 1;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            if (rvalid) begin
                seen = 1;
                chk("stall follow rdata", rdata, 64'h4242);
            end
        end
        chk("stall follow rvalid seen", seen, 1);
        @(posedge clk); #1 idle_inputs();

        // Reset during RD_WAIT drops the read.
        @(posedge clk); #1;
        arvalid = 1; araddr = 20'h00050; rready = 1; stub_data = 64'h6666; stub_err = 1;
        @(negedge clk);
        chk("rst arready", arready, 1);
        @(posedge clk); #1;
        arvalid = 0;
        @(negedge clk);
        chk("rst rd_en", csr_rd_en, 1);
        @(posedge clk); #1;
        reset_n = 0;
        @(negedge clk);
        check_zero("in reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        @(negedge clk);
        check_zero("after reset");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rst no rvalid", rvalid, 0);
        end
        v = '{1'b0, 20'h00058, 64'hCAFE_0000_BEEF_0001, 8'h00, 1'b0, 17'h0000B, 2'b00};
        do_read(v, "post-rst rd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
